// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg
// Shared types and sizing helpers for the hiscore RAM arbiter.
//   arb_state_t  : arbiter FSM state encoding
//   pad_cycles() : effective pause pad length (never below one cycle)
//   pad_width()  : width of the pad down-counter
//   hold_width() : width of the hold down-counter, clog2(HS_HOLD_MAX+1)
package hs_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_GRANT = 2'd2,
        ST_POST  = 2'd3
    } arb_state_t;

    function automatic int pad_cycles(input int pad);
        return (pad < 1) ? 1 : pad;
    endfunction

    function automatic int pad_width(input int pad);
        return $clog2(pad_cycles(pad) + 1);
    endfunction

    function automatic int hold_width(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/hs_arb_timer.sv
// hs_arb_timer
// Saturating down-counter used for the pause pads and the grant hold limit.
//   clk_memory : clock
//   reset_sw   : synchronous active-high reset, clears the count
//   load       : load load_val (takes priority over en)
//   load_val   : value loaded, i.e. remaining cycles minus one
//   en         : decrement by one, holds at zero
//   done       : count is zero
module hs_arb_timer #(
    parameter int W = 4
) (
    input  logic         clk_memory,
    input  logic         reset_sw,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk_memory) begin
        if (reset_sw) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter
// Shares one game RAM port between the core CPU and the hiscore engine.
// The core is paused for a pad period before and after every hiscore
// access window; a window is forcibly closed after HS_HOLD_MAX cycles.
//   clk_memory, reset_sw           : clock, synchronous active-high reset
//   hs_req / hs_grant              : hiscore request / ownership
//   hs_address, hs_write_en,
//   hs_data_in, hs_data_out        : hiscore RAM access
//   hs_rd_valid                    : read data valid HS_RD_DELAY after a read
//   core_addr, core_we, core_din,
//   core_dout                      : core CPU RAM side
//   ram_addr, ram_we, ram_din,
//   ram_dout                       : physical RAM port
//   core_pause                     : pause request to the core
//   hs_timeout                     : one-cycle pulse on forced release
//
// state    | meaning
// IDLE     | core owns the RAM, not paused
// PRE      | core paused, waiting out the leading pad
// GRANT    | hiscore engine owns the RAM
// POST     | core paused, RAM writes blocked, trailing pad
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int HS_AW        = 16,
    parameter int HS_PAUSE_PAD = 4,
    parameter int HS_RD_DELAY  = 2,
    parameter int HS_HOLD_MAX  = 1024
) (
    input  logic             clk_memory,
    input  logic             reset_sw,
    input  logic             hs_req,
    output logic             hs_grant,
    input  logic [HS_AW-1:0] hs_address,
    input  logic             hs_write_en,
    input  logic [7:0]       hs_data_in,
    output logic [7:0]       hs_data_out,
    output logic             hs_rd_valid,
    input  logic [HS_AW-1:0] core_addr,
    input  logic             core_we,
    input  logic [7:0]       core_din,
    output logic [7:0]       core_dout,
    output logic [HS_AW-1:0] ram_addr,
    output logic             ram_we,
    output logic [7:0]       ram_din,
    input  logic [7:0]       ram_dout,
    output logic             core_pause,
    output logic             hs_timeout
);

    localparam int PAD_N = pad_cycles(HS_PAUSE_PAD);
    localparam int PW    = pad_width(HS_PAUSE_PAD);
    localparam int HW    = hold_width(HS_HOLD_MAX);

    localparam logic [PW-1:0] PAD_LOAD  = PW'(PAD_N - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HS_HOLD_MAX - 1);

    arb_state_t state;

    logic pad_load, pad_en, pad_done;
    logic hold_load, hold_en, hold_done;
    logic [HS_RD_DELAY-1:0] rd_pipe;

    // Timers are loaded with (length - 1) on the edge that enters the
    // timed state, so done is seen in the last cycle of that state.
    always_comb begin
        pad_load  = 1'b0;
        pad_en    = 1'b0;
        hold_load = 1'b0;
        hold_en   = 1'b0;
        case (state)
            ST_IDLE:  pad_load = hs_req;
            ST_PRE: begin
                pad_en    = 1'b1;
                pad_load  = ~hs_req;
                hold_load = hs_req & pad_done;
            end
            ST_GRANT: begin
                hold_en  = 1'b1;
                pad_load = ~hs_req | hold_done;
            end
            ST_POST:  pad_en = 1'b1;
            default: ;
        endcase
    end

    hs_arb_timer #(.W(PW)) u_pad_timer (
        .clk_memory (clk_memory),
        .reset_sw   (reset_sw),
        .load       (pad_load),
        .load_val   (PAD_LOAD),
        .en         (pad_en),
        .done       (pad_done)
    );

    hs_arb_timer #(.W(HW)) u_hold_timer (
        .clk_memory (clk_memory),
        .reset_sw   (reset_sw),
        .load       (hold_load),
        .load_val   (HOLD_LOAD),
        .en         (hold_en),
        .done       (hold_done)
    );

    always_ff @(posedge clk_memory) begin
        if (reset_sw) begin
            state      <= ST_IDLE;
            core_pause <= 1'b0;
            hs_grant   <= 1'b0;
            hs_timeout <= 1'b0;
        end else begin
            hs_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Reached from POST only via at least one cycle here,
                    // so the core always gets a slot between windows.
                    if (hs_req) begin
                        state      <= ST_PRE;
                        core_pause <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (!hs_req) begin
                        state <= ST_POST;
                    end else if (pad_done) begin
                        state    <= ST_GRANT;
                        hs_grant <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // A voluntary release wins over a simultaneous timeout.
                    if (!hs_req) begin
                        state    <= ST_POST;
                        hs_grant <= 1'b0;
                    end else if (hold_done) begin
                        state      <= ST_POST;
                        hs_grant   <= 1'b0;
                        hs_timeout <= 1'b1;
                    end
                end
                ST_POST: begin
                    if (pad_done) begin
                        state      <= ST_IDLE;
                        core_pause <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    core_pause <= 1'b0;
                    hs_grant   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_memory) begin
        if (reset_sw) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe[0] <= hs_grant & ~hs_write_en;
            for (int i = 1; i < HS_RD_DELAY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign hs_rd_valid = rd_pipe[HS_RD_DELAY-1];

    assign ram_addr    = hs_grant ? hs_address  : core_addr;
    assign ram_din     = hs_grant ? hs_data_in  : core_din;
    assign ram_we      = hs_grant ? hs_write_en : (core_we & ~core_pause);
    assign core_dout   = ram_dout;
    assign hs_data_out = ram_dout;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
module tb_hs_ram_arbiter;

    localparam int AW   = 16;
    localparam int PAD  = 4;
    localparam int RD   = 2;
    localparam int HOLD = 64;

    logic          clk_memory = 1'b0;
    logic          reset_sw;
    logic          hs_req;
    logic          hs_grant;
    logic [AW-1:0] hs_address;
    logic          hs_write_en;
    logic [7:0]    hs_data_in;
    logic [7:0]    hs_data_out;
    logic          hs_rd_valid;
    logic [AW-1:0] core_addr;
    logic          core_we;
    logic [7:0]    core_din;
    logic [7:0]    core_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;
    logic          core_pause;
    logic          hs_timeout;

    int checks = 0;
    int errors = 0;

    hs_ram_arbiter #(
        .HS_AW(AW), .HS_PAUSE_PAD(PAD), .HS_RD_DELAY(RD), .HS_HOLD_MAX(HOLD)
    ) dut (
        .clk_memory (clk_memory),
        .reset_sw   (reset_sw),
        .hs_req     (hs_req),
        .hs_grant   (hs_grant),
        .hs_address (hs_address),
        .hs_write_en(hs_write_en),
        .hs_data_in (hs_data_in),
        .hs_data_out(hs_data_out),
        .hs_rd_valid(hs_rd_valid),
        .core_addr  (core_addr),
        .core_we    (core_we),
        .core_din   (core_din),
        .core_dout  (core_dout),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .core_pause (core_pause),
        .hs_timeout (hs_timeout)
    );

    always #5 clk_memory = ~clk_memory;

    // Reference model: which phase of the access protocol we are in and
    // how many cycles have been spent there, plus a history of issued reads.
    localparam int PH_IDLE = 0, PH_PRE = 1, PH_GRANT = 2, PH_POST = 3;
    int m_phase;
    int m_cycles;
    bit m_timeout;
    bit m_reads[$];

    function automatic bit m_paused();
        return m_phase != PH_IDLE;
    endfunction

    function automatic bit m_granted();
        return m_phase == PH_GRANT;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_IDLE;
        m_cycles  = 0;
        m_timeout = 0;
        m_reads.delete();
        for (int i = 0; i < RD; i++) m_reads.push_back(1'b0);
    endtask

    // Applies one clock edge using the inputs present during the cycle.
    task automatic model_advance();
        int pad_n;
        pad_n = (PAD < 1) ? 1 : PAD;
        if (reset_sw) begin
            model_reset();
            return;
        end
        m_reads.push_back(m_granted() && !hs_write_en);
        void'(m_reads.pop_front());
        m_timeout = 0;
        m_cycles++;
        case (m_phase)
            PH_IDLE: if (hs_req) begin m_phase = PH_PRE; m_cycles = 0; end
            PH_PRE: begin
                if (!hs_req) begin m_phase = PH_POST; m_cycles = 0; end
                else if (m_cycles >= pad_n) begin m_phase = PH_GRANT; m_cycles = 0; end
            end
            PH_GRANT: begin
                if (!hs_req) begin m_phase = PH_POST; m_cycles = 0; end
                else if (m_cycles >= HOLD) begin
                    m_phase = PH_POST; m_cycles = 0; m_timeout = 1;
                end
            end
            default: if (m_cycles >= pad_n) begin m_phase = PH_IDLE; m_cycles = 0; end
        endcase
    endtask

    task automatic check_all();
        logic [AW-1:0] e_addr;
        logic [7:0]    e_din;
        logic          e_we;
        e_addr = m_granted() ? hs_address : core_addr;
        e_din  = m_granted() ? hs_data_in : core_din;
        e_we   = m_granted() ? hs_write_en : (core_we && !m_paused());
        chk("core_pause", core_pause, m_paused());
        chk("hs_grant", hs_grant, m_granted());
        chk("hs_timeout", hs_timeout, m_timeout);
        chk("hs_rd_valid", hs_rd_valid, m_reads[0]);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, e_din);
        chk("ram_we", ram_we, e_we);
        chk("core_dout", core_dout, ram_dout);
        chk("hs_data_out", hs_data_out, ram_dout);
    endtask

    // Check the current cycle, clock, then fold the edge into the model.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk_memory);
        #1;
        model_advance();
    endtask

    task automatic rand_data();
        hs_address  = AW'($urandom);
        hs_write_en = 1'($urandom);
        hs_data_in  = 8'($urandom);
        core_addr   = AW'($urandom);
        core_we     = 1'($urandom);
        core_din    = 8'($urandom);
        ram_dout    = 8'($urandom);
    endtask

    task automatic do_reset();
        reset_sw = 1'b1;
        hs_req   = 1'b0;
        @(posedge clk_memory);
        #1;
        model_advance();
        reset_sw = 1'b0;
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 20 && !hs_grant; i++) begin
            rand_data();
            tick();
        end
        chk("wait_grant", hs_grant, 1'b1);
    endtask

    initial begin
        reset_sw = 1'b1;
        hs_req   = 1'b0;
        rand_data();
        model_reset();
        do_reset();
        do_reset();

        // Reset state
        core_we = 1'b1;
        #1;
        chk("rst_pause", core_pause, 1'b0);
        chk("rst_grant", hs_grant, 1'b0);
        chk("rst_rd_valid", hs_rd_valid, 1'b0);
        chk("rst_ram_we", ram_we, 1'b1);
        tick();

        // Request held 100 cycles: pad, full hold, timeout, pad, idle slot
        hs_req = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc == 1)  chk("pause_c1", core_pause, 1'b1);
            if (cyc == 4)  chk("grant_c4", hs_grant, 1'b0);
            if (cyc == 5)  chk("grant_c5", hs_grant, 1'b1);
            if (cyc == 68) chk("grant_c68", hs_grant, 1'b1);
            if (cyc == 69) begin
                chk("timeout_c69", hs_timeout, 1'b1);
                chk("grant_c69", hs_grant, 1'b0);
            end
            if (cyc == 70) chk("timeout_c70", hs_timeout, 1'b0);
            if (cyc == 72) chk("pause_c72", core_pause, 1'b1);
            if (cyc == 73) chk("idle_c73", core_pause, 1'b0);
            if (cyc == 74) chk("pre_c74", core_pause, 1'b1);
            rand_data();
            tick();
        end
        hs_req = 1'b0;
        for (int i = 0; i < 12; i++) begin rand_data(); tick(); end

        // Hiscore write beats a concurrent core write
        hs_req = 1'b1;
        wait_grant();
        rand_data();
        hs_address = 16'h0120; hs_data_in = 8'h5A; hs_write_en = 1'b1;
        core_addr = 16'h0777; core_din = 8'h33; core_we = 1'b1;
        #1;
        chk("wr_addr", ram_addr, 16'h0120);
        chk("wr_din", ram_din, 8'h5A);
        chk("wr_we", ram_we, 1'b1);
        tick();

        // Read at cycle n, data returned at n+2
        hs_address = 16'h0040; hs_write_en = 1'b0;
        tick();
        hs_write_en = 1'b1;
        tick();
        ram_dout = 8'hA5;
        #1;
        chk("rd_valid_n2", hs_rd_valid, 1'b1);
        chk("rd_data_n2", hs_data_out, 8'hA5);
        tick();

        // Release on the very cycle the hold limit is reached: no timeout
        hs_req = 1'b0;
        for (int i = 0; i < 12; i++) begin rand_data(); tick(); end
        hs_req = 1'b1;
        wait_grant();
        for (int i = 0; i < HOLD - 1; i++) begin rand_data(); tick(); end
        chk("tie_grant", hs_grant, 1'b1);
        hs_req = 1'b0;
        tick();
        chk("tie_timeout", hs_timeout, 1'b0);
        chk("tie_post", core_pause, 1'b1);
        for (int i = 0; i < 8; i++) begin rand_data(); tick(); end

        // Reset in the middle of a grant, read in flight
        hs_req = 1'b1;
        wait_grant();
        hs_write_en = 1'b0;
        tick();
        reset_sw = 1'b1;
        tick();
        reset_sw = 1'b0;
        core_we = 1'b1;
        #1;
        chk("rstg_pause", core_pause, 1'b0);
        chk("rstg_grant", hs_grant, 1'b0);
        chk("rstg_rd_valid", hs_rd_valid, 1'b0);
        chk("rstg_addr", ram_addr, core_addr);
        chk("rstg_we", ram_we, 1'b1);
        hs_req = 1'b0;
        tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            if ($urandom_range(0, 15) == 0) hs_req = ~hs_req;
            reset_sw = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset_sw = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
